// File: rtl/rvfi_commit_buffer_if.sv
// Retire-side, load-completion and RVFI output signals of the commit buffer.
// master = core/monitor side, slave = the buffer itself.
interface rvfi_commit_buffer_if #(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) ();
    localparam int TAG_W = $clog2(DEPTH);

    logic               in_valid;
    logic               in_ready;
    logic [TAG_W-1:0]   in_tag;
    logic               in_pending;
    logic [31:0]        in_inst, in_pc_rdata, in_pc_wdata;
    logic [4:0]         in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0]        in_rs1_rdata, in_rs2_rdata, in_rd_wdata;
    logic [31:0]        in_mem_addr, in_mem_wdata;
    logic [3:0]         in_mem_rmask, in_mem_wmask;

    logic               ld_valid;
    logic [TAG_W-1:0]   ld_tag;
    logic [31:0]        ld_mem_rdata, ld_rd_wdata;

    logic               rvfi_valid;
    logic [ORDER_W-1:0] rvfi_order;
    logic [31:0]        rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]         rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0]        rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0]        rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata;
    logic [3:0]         rvfi_mem_rmask, rvfi_mem_wmask;
    logic               rvfi_halt;
    logic               proto_err;

    modport master (
        output in_valid, in_pending, in_inst, in_pc_rdata, in_pc_wdata,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
               in_mem_addr, in_mem_wdata, in_mem_rmask, in_mem_wmask,
               ld_valid, ld_tag, ld_mem_rdata, ld_rd_wdata,
        input  in_ready, in_tag,
               rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata, rvfi_mem_rmask, rvfi_mem_wmask,
               rvfi_halt, proto_err
    );

    modport slave (
        input  in_valid, in_pending, in_inst, in_pc_rdata, in_pc_wdata,
               in_rs1_addr, in_rs2_addr, in_rd_addr, in_rs1_rdata, in_rs2_rdata, in_rd_wdata,
               in_mem_addr, in_mem_wdata, in_mem_rmask, in_mem_wmask,
               ld_valid, ld_tag, ld_mem_rdata, ld_rd_wdata,
        output in_ready, in_tag,
               rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
               rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
               rvfi_mem_addr, rvfi_mem_wdata, rvfi_mem_rdata, rvfi_mem_rmask, rvfi_mem_wmask,
               rvfi_halt, proto_err
    );
endinterface

// File: rtl/rvfi_commit_buffer.sv
// In-order RVFI retirement buffer: holds packets until their load data arrives,
// then emits them one per cycle with a sequential order number and sticky halt.
module rvfi_commit_buffer #(
    parameter int DEPTH   = 4,
    parameter int ORDER_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rvfi_commit_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] inst, pc_rdata, pc_wdata;
        logic [4:0]  rs1_addr, rs2_addr, rd_addr;
        logic [31:0] rs1_rdata, rs2_rdata, rd_wdata;
        logic [31:0] mem_addr, mem_wdata;
        logic [3:0]  mem_rmask, mem_wmask;
        logic [31:0] mem_rdata;
    } rvfi_t;

    typedef struct packed {
        rvfi_t f;
        logic  done;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr, ld_off;
    logic [PTR_W:0]     count;
    logic [ORDER_W-1:0] order_cnt;
    logic               halt, err, out_valid;
    rvfi_t              out_q, out_n;
    entry_t             head, in_entry;
    logic               accept, commit, ld_alloc, ld_bad, ld_wr, pend_bad, halt_hit;

    assign head     = mem[rd_ptr];
    assign bus.in_ready = (count != FULL) && !halt;
    assign bus.in_tag   = wr_ptr;
    assign accept   = bus.in_valid && bus.in_ready;
    assign commit   = (count != '0) && head.done && !halt;

    // Entry is live iff its distance from the head is below the occupancy.
    assign ld_off   = bus.ld_tag - rd_ptr;
    assign ld_alloc = ({1'b0, ld_off} < count);
    assign ld_bad   = bus.ld_valid &&
                      (!ld_alloc || mem[bus.ld_tag].done || (accept && bus.ld_tag == wr_ptr));
    assign ld_wr    = bus.ld_valid && !ld_bad && !halt;
    assign pend_bad = accept && bus.in_pending && (bus.in_mem_rmask == 4'd0);
    assign halt_hit = (head.f.pc_rdata == head.f.pc_wdata) ||
                      (head.f.inst == 32'h0000_0063) || (head.f.inst == 32'h0000_006f);

    always_comb begin
        in_entry             = '0;
        in_entry.f.inst      = bus.in_inst;
        in_entry.f.pc_rdata  = bus.in_pc_rdata;
        in_entry.f.pc_wdata  = bus.in_pc_wdata;
        in_entry.f.rs1_addr  = bus.in_rs1_addr;
        in_entry.f.rs2_addr  = bus.in_rs2_addr;
        in_entry.f.rd_addr   = bus.in_rd_addr;
        in_entry.f.rs1_rdata = bus.in_rs1_rdata;
        in_entry.f.rs2_rdata = bus.in_rs2_rdata;
        in_entry.f.rd_wdata  = bus.in_rd_wdata;
        in_entry.f.mem_addr  = bus.in_mem_addr;
        in_entry.f.mem_wdata = bus.in_mem_wdata;
        in_entry.f.mem_rmask = bus.in_mem_rmask;
        in_entry.f.mem_wmask = bus.in_mem_wmask;
        in_entry.done        = !bus.in_pending;
    end

    // Zero values the monitor must not see for x0 / masked-off reads.
    always_comb begin
        out_n = head.f;
        if (head.f.rs1_addr == 5'd0)   out_n.rs1_rdata = '0;
        if (head.f.rs2_addr == 5'd0)   out_n.rs2_rdata = '0;
        if (head.f.rd_addr == 5'd0)    out_n.rd_wdata  = '0;
        if (head.f.mem_rmask == 4'd0)  out_n.mem_rdata = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (accept) mem[wr_ptr] <= in_entry;
            if (ld_wr) begin
                mem[bus.ld_tag].f.mem_rdata <= bus.ld_mem_rdata;
                mem[bus.ld_tag].f.rd_wdata  <= bus.ld_rd_wdata;
                mem[bus.ld_tag].done        <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            order_cnt <= '0;
            halt      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (accept && !commit)      count <= count + 1'b1;
            else if (!accept && commit) count <= count - 1'b1;
            if (ld_bad || pend_bad) err <= 1'b1;
            out_valid <= commit;
            if (commit) begin
                out_q     <= out_n;
                rd_ptr    <= rd_ptr + 1'b1;
                order_cnt <= order_cnt + 1'b1;
                if (halt_hit) halt <= 1'b1;
            end
        end
    end

    // rvfi_order is the counter value before the commit's increment.
    logic [ORDER_W-1:0] order_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      order_q <= '0;
        else if (commit) order_q <= order_cnt;
    end

    assign bus.rvfi_valid     = out_valid;
    assign bus.rvfi_order     = order_q;
    assign bus.rvfi_inst      = out_q.inst;
    assign bus.rvfi_pc_rdata  = out_q.pc_rdata;
    assign bus.rvfi_pc_wdata  = out_q.pc_wdata;
    assign bus.rvfi_rs1_addr  = out_q.rs1_addr;
    assign bus.rvfi_rs2_addr  = out_q.rs2_addr;
    assign bus.rvfi_rd_addr   = out_q.rd_addr;
    assign bus.rvfi_rs1_rdata = out_q.rs1_rdata;
    assign bus.rvfi_rs2_rdata = out_q.rs2_rdata;
    assign bus.rvfi_rd_wdata  = out_q.rd_wdata;
    assign bus.rvfi_mem_addr  = out_q.mem_addr;
    assign bus.rvfi_mem_wdata = out_q.mem_wdata;
    assign bus.rvfi_mem_rdata = out_q.mem_rdata;
    assign bus.rvfi_mem_rmask = out_q.mem_rmask;
    assign bus.rvfi_mem_wmask = out_q.mem_wmask;
    assign bus.rvfi_halt      = halt;
    assign bus.proto_err      = err;
endmodule

// File: tb/tb_rvfi_commit_buffer.sv
// Random + directed bench for rvfi_commit_buffer against a queue-based program-order model.
module tb_rvfi_commit_buffer;
    localparam int DEPTH = 4;
    localparam int ORDER_W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rvfi_commit_buffer_if #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) bus ();
    rvfi_commit_buffer #(.DEPTH(DEPTH), .ORDER_W(ORDER_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    typedef struct {
        logic [31:0] inst, pc_r, pc_w;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] rs1d, rs2d, rdd, maddr, mwd, mrd;
        logic [3:0]  rm, wm;
        logic        pend, done;
        int          tag;
        logic [63:0] ord;
    } pkt_t;

    int checks = 0;
    int errors = 0;

    // Model state: in-flight packets in program order, expected commits awaiting the monitor.
    pkt_t mq[$];
    pkt_t exp_q[$];
    int   m_wr;
    logic [63:0] m_order;
    bit   m_halt, m_err, m_exp_valid, m_acc;
    bit   rdy, com, acc;
    int   idx;
    pkt_t p, e;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t clean(pkt_t x);
        pkt_t y = x;
        if (x.rs1 == 0) y.rs1d = 0;
        if (x.rs2 == 0) y.rs2d = 0;
        if (x.rd == 0)  y.rdd = 0;
        if (x.rm == 0)  y.mrd = 0;
        return y;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); exp_q.delete();
            m_wr = 0; m_order = 0; m_halt = 0; m_err = 0; m_exp_valid = 0; m_acc = 0;
        end else begin
            rdy = (mq.size() != DEPTH) && !m_halt;
            com = (mq.size() != 0) && mq[0].done && !m_halt;
            acc = bus.in_valid && rdy;
            m_acc = acc;
            if (bus.ld_valid) begin
                idx = -1;
                foreach (mq[i]) if (mq[i].tag == int'(bus.ld_tag)) idx = i;
                if (idx < 0 || mq[idx].done) m_err = 1;
                else if (!m_halt) begin
                    mq[idx].mrd  = bus.ld_mem_rdata;
                    mq[idx].rdd  = bus.ld_rd_wdata;
                    mq[idx].done = 1;
                end
            end
            m_exp_valid = com;
            if (com) begin
                p = mq.pop_front();
                if (p.pc_r == p.pc_w || p.inst == 32'h63 || p.inst == 32'h6f) m_halt = 1;
                p = clean(p);
                p.ord = m_order;
                m_order++;
                exp_q.push_back(p);
            end
            if (acc) begin
                p.inst = bus.in_inst; p.pc_r = bus.in_pc_rdata; p.pc_w = bus.in_pc_wdata;
                p.rs1 = bus.in_rs1_addr; p.rs2 = bus.in_rs2_addr; p.rd = bus.in_rd_addr;
                p.rs1d = bus.in_rs1_rdata; p.rs2d = bus.in_rs2_rdata; p.rdd = bus.in_rd_wdata;
                p.maddr = bus.in_mem_addr; p.mwd = bus.in_mem_wdata; p.mrd = 0;
                p.rm = bus.in_mem_rmask; p.wm = bus.in_mem_wmask;
                p.pend = bus.in_pending; p.done = !bus.in_pending; p.tag = m_wr; p.ord = 0;
                if (bus.in_pending && bus.in_mem_rmask == 0) m_err = 1;
                mq.push_back(p);
                m_wr = (m_wr + 1) % DEPTH;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", 64'(bus.in_ready), 64'((mq.size() != DEPTH) && !m_halt));
            chk("in_tag", 64'(bus.in_tag), 64'(m_wr));
            chk("rvfi_valid", 64'(bus.rvfi_valid), 64'(m_exp_valid));
            chk("rvfi_halt", 64'(bus.rvfi_halt), 64'(m_halt));
            chk("proto_err", 64'(bus.proto_err), 64'(m_err));
            if (bus.rvfi_valid) begin
                if (exp_q.size() == 0) chk("unexpected_commit", 64'(1), 64'(0));
                else begin
                    e = exp_q.pop_front();
                    chk("order", bus.rvfi_order, e.ord);
                    chk("inst", 64'(bus.rvfi_inst), 64'(e.inst));
                    chk("pc_rdata", 64'(bus.rvfi_pc_rdata), 64'(e.pc_r));
                    chk("pc_wdata", 64'(bus.rvfi_pc_wdata), 64'(e.pc_w));
                    chk("regs_addr", 64'({bus.rvfi_rs1_addr, bus.rvfi_rs2_addr, bus.rvfi_rd_addr}),
                        64'({e.rs1, e.rs2, e.rd}));
                    chk("rs_rdata", {bus.rvfi_rs1_rdata, bus.rvfi_rs2_rdata}, {e.rs1d, e.rs2d});
                    chk("rd_wdata", 64'(bus.rvfi_rd_wdata), 64'(e.rdd));
                    chk("mem_addr_wdata", {bus.rvfi_mem_addr, bus.rvfi_mem_wdata}, {e.maddr, e.mwd});
                    chk("mem_rdata", 64'(bus.rvfi_mem_rdata), 64'(e.mrd));
                    chk("masks", 64'({bus.rvfi_mem_rmask, bus.rvfi_mem_wmask}), 64'({e.rm, e.wm}));
                end
            end
        end
    end

    function automatic pkt_t mk(logic [31:0] inst, logic [4:0] rd, logic [31:0] rdd,
                                logic pend, logic [3:0] rm);
        pkt_t x;
        x.inst = inst; x.pc_r = $urandom & ~32'h3; x.pc_w = x.pc_r + 4;
        x.rs1 = 5'($urandom); x.rs2 = 5'($urandom); x.rd = rd;
        x.rs1d = $urandom; x.rs2d = $urandom; x.rdd = rdd;
        x.maddr = $urandom; x.mwd = $urandom; x.mrd = 0;
        x.rm = rm; x.wm = 4'($urandom); x.pend = pend; x.done = !pend; x.tag = 0; x.ord = 0;
        return x;
    endfunction

    function automatic pkt_t rnd();
        logic pend = ($urandom_range(0, 2) == 0);
        logic [3:0] rm = ($urandom_range(0, 15) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        return mk($urandom | 32'h8000_0000, 5'($urandom), $urandom, pend, rm);
    endfunction

    task automatic drive_pkt(pkt_t x);
        bus.in_valid = 1; bus.in_pending = x.pend; bus.in_inst = x.inst;
        bus.in_pc_rdata = x.pc_r; bus.in_pc_wdata = x.pc_w;
        bus.in_rs1_addr = x.rs1; bus.in_rs2_addr = x.rs2; bus.in_rd_addr = x.rd;
        bus.in_rs1_rdata = x.rs1d; bus.in_rs2_rdata = x.rs2d; bus.in_rd_wdata = x.rdd;
        bus.in_mem_addr = x.maddr; bus.in_mem_wdata = x.mwd;
        bus.in_mem_rmask = x.rm; bus.in_mem_wmask = x.wm;
    endtask

    task automatic send(pkt_t x);
        bit ok = 0;
        drive_pkt(x);
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = m_acc;
        end
        if (!ok) chk("send_timeout", 64'(0), 64'(1));
        bus.in_valid = 0;
    endtask

    task automatic ld(int tag, logic [31:0] mrd, logic [31:0] rwd);
        bus.ld_valid = 1; bus.ld_tag = 2'(tag); bus.ld_mem_rdata = mrd; bus.ld_rd_wdata = rwd;
        @(negedge clk);
        bus.ld_valid = 0;
    endtask

    task automatic idle(int n);
        bus.in_valid = 0; bus.ld_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        idle(1);
        #1 rst_n = 0;
        #2 rst_n = 1;
    endtask

    int pend_tags[$];

    initial begin
        bus.in_valid = 0; bus.ld_valid = 0; bus.ld_tag = 0;
        bus.ld_mem_rdata = 0; bus.ld_rd_wdata = 0;
        drive_pkt(mk(0, 0, 0, 0, 0));
        bus.in_valid = 0;
        #1;
        chk("rst_valid", 64'(bus.rvfi_valid), 64'(0));
        chk("rst_order", bus.rvfi_order, 64'(0));
        chk("rst_fields", {bus.rvfi_inst, bus.rvfi_rd_wdata}, 64'(0));
        chk("rst_halt_err", 64'({bus.rvfi_halt, bus.proto_err}), 64'(0));
        chk("rst_ready_tag", 64'({bus.in_ready, bus.in_tag}), 64'(3'b100));
        #10 rst_n = 1;

        // Back-to-back ALU packets, middle one writes x0.
        send(mk(32'h0000_0013, 5'd3, 32'h11, 0, 0));
        send(mk(32'h0000_0093, 5'd0, 32'h55, 0, 0));
        send(mk(32'h0000_0113, 5'd4, 32'h22, 0, 0));
        idle(4);

        // Pending load at the head blocks two younger ALU packets.
        do_reset();
        send(mk(32'h0000_2003, 5'd5, 32'h0, 1, 4'hf));
        send(mk(32'h0000_0013, 5'd6, 32'h1, 0, 0));
        send(mk(32'h0000_0013, 5'd7, 32'h2, 0, 0));
        idle(1);
        ld(0, 32'hDEADBEEF, 32'hFFFFFFEF);
        idle(5);

        // Fill to DEPTH behind a pending head; fifth packet waits for space.
        do_reset();
        send(mk(32'h0000_2003, 5'd1, 0, 1, 4'hf));
        for (int i = 0; i < 3; i++) send(mk(32'h0000_0013, 5'(i + 8), $urandom, 0, 0));
        fork
            send(mk(32'h0000_0013, 5'd12, 32'h5, 0, 0));
            begin
                repeat (3) @(negedge clk);
                chk("full_not_ready", 64'(bus.in_ready), 64'(0));
                ld(0, 32'hA5A5_0000, 32'h1234);
            end
        join
        idle(8);

        // Halting instruction freezes the buffer.
        do_reset();
        send(mk(32'h0000_006f, 5'd1, 32'h9, 0, 0));
        send(mk(32'h0000_0013, 5'd2, 32'h8, 0, 0));
        idle(6);
        chk("halt_sticky", 64'({bus.rvfi_halt, bus.in_ready}), 64'(2'b10));

        // Load response to an already-done entry is a protocol error.
        do_reset();
        send(mk(32'h0000_2003, 5'd9, 0, 1, 4'h3));
        send(mk(32'h0000_0013, 5'd10, 32'h77, 0, 0));
        ld(1, 32'hBAD0_BAD0, 32'hBAD1_BAD1);
        idle(2);
        ld(0, 32'h0000_BEEF, 32'h0000_00EF);
        idle(5);

        // Reset while a commit is on the bus and two entries remain buffered.
        do_reset();
        send(mk(32'h0000_2003, 5'd1, 0, 1, 4'hf));
        send(mk(32'h0000_0013, 5'd2, 32'h3, 0, 0));
        send(mk(32'h0000_0013, 5'd3, 32'h4, 0, 0));
        ld(0, 32'h1, 32'h2);
        @(negedge clk);
        chk("pre_reset_valid", 64'(bus.rvfi_valid), 64'(1));
        #1 rst_n = 0;
        #1 chk("async_reset_valid", 64'(bus.rvfi_valid), 64'(0));
        #1 rst_n = 1;
        send(mk(32'h0000_0013, 5'd4, 32'h5, 0, 0));
        idle(3);

        // Random traffic with occasional bad load responses.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!bus.in_valid || m_acc) begin
                if ($urandom_range(0, 9) < 6) drive_pkt(rnd());
                else bus.in_valid = 0;
            end
            bus.ld_valid = 0;
            if ($urandom_range(0, 9) < 3) begin
                pend_tags.delete();
                foreach (mq[i]) if (!mq[i].done) pend_tags.push_back(mq[i].tag);
                bus.ld_valid = 1;
                bus.ld_mem_rdata = $urandom; bus.ld_rd_wdata = $urandom;
                if (pend_tags.size() != 0 && $urandom_range(0, 9) != 0)
                    bus.ld_tag = 2'(pend_tags[$urandom_range(0, pend_tags.size() - 1)]);
                else bus.ld_tag = 2'($urandom);
            end
            @(negedge clk);
        end
        bus.in_valid = 0; bus.ld_valid = 0;
        for (int c = 0; c < 40; c++) begin
            bus.ld_valid = 0;
            foreach (mq[i]) if (!mq[i].done && !bus.ld_valid) begin
                bus.ld_valid = 1; bus.ld_tag = 2'(mq[i].tag);
                bus.ld_mem_rdata = $urandom; bus.ld_rd_wdata = $urandom;
            end
            @(negedge clk);
        end
        idle(5);
        chk("drained", 64'(exp_q.size() + mq.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rvfi_commit_buffer.md
Name: rvfi_commit_buffer

Overview:
- Producer side of the RVFI retirement interface.
- Sits between the core's writeback/commit stage and the RVFI monitor.
- Accepts one retired-instruction packet per cycle, holds packets whose load data is still outstanding, and emits them strictly in program order on a registered RVFI bus.
- Assigns the `order` number and drives `halt`.

Parameters:
- DEPTH, 4, number of in-flight retire entries; power of 2, ≥2.
- ORDER_W, 64, width of the commit order counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  retire packet present.
- in_ready  output  1  buffer can accept a packet.
- in_tag  output  $clog2(DEPTH)  entry index allocated to the current packet.
- in_pending  input  1  load data not yet known for this packet.
- in_inst, in_pc_rdata, in_pc_wdata  input  32 each  instruction word, PC, next PC.
- in_rs1_addr, in_rs2_addr, in_rd_addr  input  5 each  register indices.
- in_rs1_rdata, in_rs2_rdata, in_rd_wdata  input  32 each  register values.
- in_mem_addr, in_mem_wdata  input  32 each  memory address, store data.
- in_mem_rmask, in_mem_wmask  input  4 each  byte masks.
- ld_valid  input  1  load completion.
- ld_tag  input  $clog2(DEPTH)  entry being completed.
- ld_mem_rdata, ld_rd_wdata  input  32 each  load memory data and final rd value.
- rvfi_valid  output  1  commit strobe.
- rvfi_order  output  ORDER_W  commit sequence number.
- rvfi_<field>  output  same widths as in_<field>, for every in_ field listed above except in_pending.
- rvfi_mem_rdata  output  32  load data.
- rvfi_halt  output  1  sticky halt.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Storage: circular buffer with wr_ptr, rd_ptr, count (0..DEPTH). Each entry holds all packet fields, mem_rdata and a done bit.
- Reset: asynchronous on rst_n low.
  - Pointers, count and all entries are cleared; buffered packets are discarded.
  - rvfi_valid=0, all rvfi_* fields=0, rvfi_order=0, rvfi_halt=0, proto_err=0.
  - Reset mid-stream drops rvfi_valid immediately, without waiting for a clock edge.
- Accept:
  - in_ready = (count != DEPTH) && !rvfi_halt.
  - in_tag = wr_ptr, combinational.
  - On in_valid && in_ready: write the entry, done = !in_pending, mem_rdata = 0, wr_ptr++ (wraps mod DEPTH).
  - in_valid while !in_ready is ignored; upstream holds the packet.
- Load completion: ld_valid to an allocated entry with done=0 writes mem_rdata, overwrites rd_wdata and sets done.
  - Any other ld_valid sets proto_err: entry not allocated, already done, or equal to the entry being written this cycle. That ld_valid is otherwise ignored.
  - in_pending with in_mem_rmask==0 also sets proto_err; the entry still waits for ld_valid.
- Commit: if count != 0, head entry done=1 and !rvfi_halt, then at the next edge:
  - rvfi_valid=1, rvfi fields = head fields, rvfi_order = order counter;
  - order counter ++ (wraps mod 2^ORDER_W), rd_ptr++.
  - Otherwise rvfi_valid=0 at that edge and the other rvfi fields hold.
  - At most one commit per cycle; no bypass.
- Latency:
  - A non-pending packet accepted at edge E into an empty buffer is presented after edge E+1.
  - A head completed by ld_valid at edge L is presented after edge L+1.
- Output cleanup:
  - rvfi_rs1_rdata=0 when rs1_addr=0; rvfi_rs2_rdata=0 when rs2_addr=0.
  - rvfi_rd_wdata=0 when rd_addr=0.
  - rvfi_mem_rdata=0 when rmask=0.
- Simultaneous accept and commit: count unchanged. in_ready uses the current count only (no same-cycle freeing).
- Halt: set on the same edge as a commit whose pc_rdata==pc_wdata, or whose inst is 0x00000063 or 0x0000006f.
  - rvfi_halt rises in the same cycle as that commit's rvfi_valid.
  - Afterwards: no further commits, in_ready=0, buffer contents frozen until reset.

Test Plan:
- Three non-pending packets on consecutive cycles (the second with rd_addr=0, rd_wdata=0x55) -> rvfi_valid on three consecutive cycles starting one cycle after the first accept; orders 0,1,2; second shows rd_wdata=0.
- Pending load (tag 0), then two ALU packets; ld_valid tag 0 three cycles later with mem_rdata=0xDEADBEEF, rd_wdata=0xFFFFFFEF -> no commit before the response; then the load (order 0, those values) and the ALUs (orders 1, 2) on three consecutive cycles.
- DEPTH=4 with a pending head and four packets pushed -> in_ready=0 while a fifth is presented; after completing the head, one commit per cycle; in_ready=1 the cycle after the first commit; the fifth is accepted then and commits last with order 4.
- Packet with inst=0x0000006f -> rvfi_halt=1 in the same cycle as its rvfi_valid; a following buffered packet never commits; in_ready stays 0.
- ld_valid to a tag whose entry is done -> proto_err=1 and stays 1; entry data unchanged; later commits unaffected.
- rst_n low mid-stream with 2 entries buffered -> rvfi_valid=0 immediately; after release the next packet commits with order 0.
